writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_match.sv | 34 +++
 rtl/writeback_queue.sv | 119 +++++++++++
 tb/tb_writeback_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the queued writeback entry type for the writeback queue.
package wb_pkg;

    localparam int XLEN          = 64;
    localparam int REG_ADDR_W    = 5;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-first search of the live queue entries for a source register address.
// Purely combinational; address 0 never hits.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = 64,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd_i,
    input  logic [DEPTH-1:0][DW-1:0]         ent_data_i,
    input  logic [PW-1:0]                    head_i,
    input  logic [PW:0]                      count_i,
    input  logic [REG_ADDR_W-1:0]            rs_i,
    output logic                             hit_o,
    output logic [DW-1:0]                    data_o
);

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if (((PW+1)'(i) < count_i) && (rs_i != '0) && (ent_rd_i[idx] == rs_i)) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU/load results into an in-order FIFO drained one entry per cycle.
// Head is presented to the register file combinationally; ready drops only when the queue is full.
module writeback_queue
    import wb_pkg::REG_ADDR_W;
    import wb_pkg::DEFAULT_DEPTH;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_hit,
    output logic [XLEN-1:0]       rs1_data,
    output logic                  rs2_hit,
    output logic [XLEN-1:0]       rs2_data,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0][XLEN-1:0]       data_q;
    logic [PW-1:0]                    head_q, head_d;
    logic [PW-1:0]                    tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d;

    logic                  ld_acc, alu_acc, enq, deq;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [XLEN-1:0]       in_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // While reset is held the queue is treated as not full, so offers see ready.
    assign ld_ready  = reset || !full;
    assign alu_ready = (reset || !full) && !ld_valid;

    assign ld_acc  = ld_valid && ld_ready;
    assign alu_acc = alu_valid && alu_ready;
    assign in_rd   = ld_acc ? ld_rd   : alu_rd;
    assign in_data = ld_acc ? ld_data : alu_data;

    // Writes to x0 are accepted from the producer but dropped here.
    assign enq = (ld_acc || alu_acc) && (in_rd != '0) && !reset;
    assign deq = !empty;

    always_comb begin
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: every read of it is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

    assign rf_we    = !empty;
    assign rf_rd    = empty ? '0 : rd_q[head_q];
    assign rf_wdata = empty ? '0 : data_q[head_q];

    wb_match #(
        .DEPTH (DEPTH),
        .DW    (XLEN)
    ) u_match_rs1 (
        .ent_rd_i   (rd_q),
        .ent_data_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .rs_i       (rs1),
        .hit_o      (rs1_hit),
        .data_o     (rs1_data)
    );

    wb_match #(
        .DEPTH (DEPTH),
        .DW    (XLEN)
    ) u_match_rs2 (
        .ent_rd_i   (rd_q),
        .ent_data_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .rs_i       (rs2),
        .hit_o      (rs2_hit),
        .data_o     (rs2_data)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_rd, ld_rd, rs1, rs2;
    logic [63:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, rf_we, rs1_hit, rs2_hit, full, empty;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata, rs1_data, rs2_data;
    logic [2:0]  count;

    always #5 clk = ~clk;

    writeback_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_hit   (rs1_hit),
        .rs1_data  (rs1_data),
        .rs2_hit   (rs2_hit),
        .rs2_data  (rs2_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    wb_entry_t q[$];
    int nvec = 0;
    int nerr = 0;

    logic        obs_we, obs_ldr, obs_alur, obs_h1, obs_h2, obs_empty;
    logic [4:0]  obs_rd;
    logic [63:0] obs_wdata, obs_d1, obs_d2;
    logic [2:0]  obs_count;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void lookup(input logic [4:0] rs, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == rs) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        logic        room, h1, h2;
        logic [63:0] d1, d2;
        room = reset || (q.size() < DEPTH);
        lookup(rs1, h1, d1);
        lookup(rs2, h2, d2);
        chk_val("ld_ready",  ld_ready,  room);
        chk_val("alu_ready", alu_ready, room && !ld_valid);
        chk_val("rf_we",     rf_we,     q.size() != 0);
        chk_val("rf_rd",     rf_rd,     q.size() != 0 ? 64'(q[0].rd) : 64'd0);
        chk_val("rf_wdata",  rf_wdata,  q.size() != 0 ? q[0].data : 64'd0);
        chk_val("count",     count,     q.size());
        chk_val("full",      full,      q.size() == DEPTH);
        chk_val("empty",     empty,     q.size() == 0);
        chk_val("rs1_hit",   rs1_hit,   h1);
        chk_val("rs1_data",  rs1_data,  d1);
        chk_val("rs2_hit",   rs2_hit,   h2);
        chk_val("rs2_data",  rs2_data,  d2);
        obs_we = rf_we;     obs_rd = rf_rd;       obs_wdata = rf_wdata;
        obs_ldr = ld_ready; obs_alur = alu_ready; obs_count = count;
        obs_h1 = rs1_hit;   obs_d1 = rs1_data;    obs_h2 = rs2_hit;
        obs_d2 = rs2_data;  obs_empty = empty;
    endtask

    // Clock-edge behaviour from the rules: reset clears, head retires, at most one offer (load first) joins.
    task automatic model_edge();
        bit        room;
        wb_entry_t e;
        room = q.size() < DEPTH;
        if (reset) begin
            q.delete();
        end else begin
            if (q.size() != 0) void'(q.pop_front());
            if (ld_valid && room) begin
                e.rd = ld_rd; e.data = ld_data;
                if (ld_rd != 0) q.push_back(e);
            end else if (alu_valid && room) begin
                e.rd = alu_rd; e.data = alu_data;
                if (alu_rd != 0) q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                         input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; ld_valid = lv; ld_rd = lr; ld_data = ld;
        alu_valid = av; alu_rd = ar; alu_data = ad; rs1 = r1; rs2 = r2;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, r1, r2);
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0; rs1 = '0; rs2 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        chk_val("reset_empty", obs_empty, 1'b1);
        chk_val("reset_count", obs_count, 3'd0);

        // Single ALU write reaches the register file the following cycle.
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk_val("alu_we",    obs_we, 1'b1);
        chk_val("alu_rd",    obs_rd, 5'd5);
        chk_val("alu_wdata", obs_wdata, 64'h1234);
        idle(5'd0, 5'd0);
        chk_val("alu_drained", obs_empty, 1'b1);

        // Load wins over ALU; ALU retries and lands one cycle behind.
        cycle(1'b0, 1'b1, 5'd3, 64'hA, 1'b1, 5'd4, 64'hB, 5'd0, 5'd0);
        chk_val("prio_ld_ready",  obs_ldr, 1'b1);
        chk_val("prio_alu_ready", obs_alur, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'hB, 5'd0, 5'd0);
        chk_val("prio_first_rd", obs_rd, 5'd3);
        idle(5'd0, 5'd0);
        chk_val("prio_second_rd",   obs_rd, 5'd4);
        chk_val("prio_second_data", obs_wdata, 64'hB);

        // x0 write is consumed but never queued.
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk_val("x0_count", obs_count, 3'd0);
        chk_val("x0_we",    obs_we, 1'b0);

        // Same rd twice: lookup sees the pending value, rs2=0 never hits.
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h11, 5'd7, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h22, 5'd7, 5'd0);
        chk_val("fwd_first", obs_d1, 64'h11);
        idle(5'd7, 5'd0);
        chk_val("fwd_hit",    obs_h1, 1'b1);
        chk_val("fwd_young",  obs_d1, 64'h22);
        chk_val("fwd_rs2_x0", obs_h2, 1'b0);

        // Back-to-back offers wrap the pointers past DEPTH while keeping order.
        for (int i = 1; i <= 6; i++)
            cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 64'(i * 16), 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk_val("wrap_last_rd", obs_rd, 5'd6);
        chk_val("wrap_last_data", obs_wdata, 64'd96);

        // Reset with a pending entry and a live offer discards both.
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h55, 5'd0, 5'd0);
        cycle(1'b1, 1'b1, 5'd10, 64'h66, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
        chk_val("rst_ld_ready", obs_ldr, 1'b1);
        idle(5'd10, 5'd9);
        chk_val("rst_we",    obs_we, 1'b0);
        chk_val("rst_count", obs_count, 3'd0);
        chk_val("rst_hit",   obs_h1, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 49) == 0),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 4) < 3, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
